// File: rtl/rgb_pwm_driver_if.sv
// Fade-generator to PWM-driver link: commanded duty word plus colour select.
interface rgb_pwm_driver_if #(
  parameter int unsigned VAL_W = 11
) ();

  logic [VAL_W-1:0] pwm_value;
  logic [1:0]       state;

  // Fade generator drives the duty and the channel it applies to
  modport master (
    output pwm_value,
    output state
  );

  // PWM driver consumes both every cycle
  modport slave (
    input pwm_value,
    input state
  );

endinterface : rgb_pwm_driver_if

// File: rtl/rgb_pwm_driver.sv
// Three-channel period-aligned PWM driver for the board RGB LED.
// Each channel latches its last commanded duty into a hold register and
// only adopts it at a period boundary, so pulses are never cut short or
// stretched mid-period.
module rgb_pwm_driver #(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  rgb_pwm_driver_if.slave        fade,
  output logic [2:0]             led,
  output logic                   period_start
);

  localparam int unsigned VAL_W  = $clog2(PWM_INTERVAL);
  localparam int unsigned CNT_W  = $clog2(PWM_INTERVAL);
  localparam int unsigned DUTY_W = VAL_W + 1;
  localparam int unsigned NCH    = 3;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PWM_INTERVAL - 1);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_INTERVAL);
  localparam logic [2:0]        LED_OFF   = {3{ACTIVE_LOW}};

  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [NCH-1:0][DUTY_W-1:0]   hold_q, hold_d;
  logic [NCH-1:0][DUTY_W-1:0]   active_q, active_d;
  logic [2:0]                   led_q, led_d;
  logic                         period_start_q, period_start_d;

  logic                         wrap_c;
  logic [DUTY_W-1:0]            duty_raw_c;
  logic [DUTY_W-1:0]            duty_clamped_c;
  logic [2:0]                   on_c;

  // Clamp the incoming duty word to full scale
  always_comb begin
    duty_raw_c     = DUTY_W'(fade.pwm_value);
    duty_clamped_c = duty_raw_c;
    if (duty_raw_c > DUTY_FULL) begin
      duty_clamped_c = DUTY_FULL;
    end
  end

  // Next-state logic: counter, hold/shadow duties, registered pin drive
  always_comb begin
    cnt_d          = cnt_q;
    hold_d         = hold_q;
    active_d       = active_q;
    led_d          = led_q;
    period_start_d = period_start_q;
    on_c           = 3'b000;

    wrap_c = (cnt_q == CNT_LAST);

    if (wrap_c) begin
      cnt_d    = '0;
      // Shadow load sees the pre-edge hold value; a write on this edge waits a period
      active_d = hold_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (fade.state)
      2'd0:    hold_d[0] = duty_clamped_c;
      2'd1:    hold_d[1] = duty_clamped_c;
      2'd2:    hold_d[2] = duty_clamped_c;
      default: hold_d    = hold_q;
    endcase

    for (int c = 0; c < int'(NCH); c++) begin
      on_c[c] = (DUTY_W'(cnt_q) < active_q[c]);
    end

    led_d          = on_c ^ LED_OFF;
    period_start_d = (cnt_q == '0);
  end

  // State register with synchronous reset taking priority over every update
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      hold_q         <= '0;
      active_q       <= '0;
      led_q          <= LED_OFF;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      active_q       <= active_d;
      led_q          <= led_d;
      period_start_q <= period_start_d;
    end
  end

  assign led          = led_q;
  assign period_start = period_start_q;

endmodule : rgb_pwm_driver

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: the stimulus side runs a period-level
// reference model and queues the expected pins for every clock; a monitor
// pops and compares at the falling edge and also tallies on-cycles per period.
module tb_rgb_pwm_driver;

  localparam int PERIOD = 1200;
  localparam int VAL_W  = $clog2(PERIOD);

  typedef struct packed {
    logic [2:0] led;
    logic       ps;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] led;
  logic       period_start;

  rgb_pwm_driver_if #(.VAL_W(VAL_W)) fif ();

  rgb_pwm_driver #(
    .PWM_INTERVAL (PERIOD),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fade         (fif.slave),
    .led          (led),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];

  // Reference model: cycles since reset, commanded and in-force duty per channel
  int m_n;
  int m_hold[3];
  int m_act[3];

  // Monitor-side per-period on-cycle tallies
  int acc[3];
  int last_cnt[3];
  int periods_seen = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_edge(input logic r, input logic [1:0] st, input int v);
    exp_t e;
    int   pos;
    if (r) begin
      e.led = 3'b111;
      e.ps  = 1'b0;
      m_n   = 0;
      for (int c = 0; c < 3; c++) begin
        m_hold[c] = 0;
        m_act[c]  = 0;
      end
    end else begin
      pos  = m_n % PERIOD;
      e.ps = (pos == 0);
      for (int c = 0; c < 3; c++) e.led[c] = !(pos < m_act[c]);
      if (pos == PERIOD - 1) begin
        for (int c = 0; c < 3; c++) m_act[c] = m_hold[c];
      end
      if (st != 2'd3) m_hold[st] = (v > PERIOD) ? PERIOD : v;
      m_n++;
    end
    exp_q.push_back(e);
  endtask

  // One clock: drive, let the edge happen, model it, wait for the monitor
  task automatic step(input logic r, input logic [1:0] st, input int v);
    rst           = r;
    fif.state     = st;
    fif.pwm_value = VAL_W'(v);
    @(posedge clk);
    model_edge(r, st, v);
    @(negedge clk);
    #1;
  endtask

  task automatic run_ps(input logic [1:0] st, input int v);
    int start;
    int k;
    start = periods_seen;
    k     = 0;
    while (periods_seen == start && k < PERIOD + 100) begin
      step(1'b0, st, v);
      k++;
    end
    if (periods_seen == start) check("period_start_timeout", 0, 1);
  endtask

  task automatic check_period(input string tag, input int r, input int g, input int b);
    check({tag, "_R_on"}, last_cnt[0], r);
    check({tag, "_G_on"}, last_cnt[1], g);
    check({tag, "_B_on"}, last_cnt[2], b);
  endtask

  // Monitor: per-cycle scoreboard compare plus per-period on-cycle counting
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led", int'(led), int'(e.led));
      check("period_start", int'(period_start), int'(e.ps));
    end
    if (period_start === 1'b1) begin
      for (int c = 0; c < 3; c++) begin
        last_cnt[c] = acc[c];
        acc[c]      = (led[c] === 1'b0) ? 1 : 0;
      end
      periods_seen++;
    end else begin
      for (int c = 0; c < 3; c++) if (led[c] === 1'b0) acc[c]++;
    end
  end

  initial begin
    int bnd_v[3];
    int bnd_e[3];
    for (int c = 0; c < 3; c++) begin
      acc[c]      = 0;
      last_cnt[c] = 0;
    end
    rst           = 1'b1;
    fif.state     = 2'd3;
    fif.pwm_value = '0;

    // Reset held for three cycles
    repeat (3) step(1'b1, 2'd3, 0);

    // Steady duty on red
    run_ps(2'd0, 300);
    run_ps(2'd0, 300);
    run_ps(2'd0, 300);
    check_period("steady300", 300, 0, 0);

    // Duty change mid-period only takes effect next period
    repeat (500) step(1'b0, 2'd0, 300);
    run_ps(2'd0, 600);
    check_period("midchg_old", 300, 0, 0);
    run_ps(2'd0, 600);
    check_period("midchg_new", 600, 0, 0);

    // Bounds: zero, full scale, over-range clamp
    bnd_v[0] = 0;    bnd_e[0] = 0;
    bnd_v[1] = 1200; bnd_e[1] = 1200;
    bnd_v[2] = 1500; bnd_e[2] = 1200;
    for (int i = 0; i < 3; i++) begin
      run_ps(2'd0, bnd_v[i]);
      run_ps(2'd0, bnd_v[i]);
      check($sformatf("bound%0d_R_on", bnd_v[i]), last_cnt[0], bnd_e[i]);
    end

    // Per-channel hold; state 3 writes nothing
    step(1'b0, 2'd0, 400);
    step(1'b0, 2'd1, 800);
    run_ps(2'd3, 100);
    run_ps(2'd3, 100);
    check_period("hold", 400, 800, 0);

    // All channels at 600, then reset in the middle of a period
    step(1'b0, 2'd0, 600);
    step(1'b0, 2'd1, 600);
    step(1'b0, 2'd2, 600);
    run_ps(2'd3, 0);
    run_ps(2'd3, 0);
    check_period("all600", 600, 600, 600);
    repeat (700) step(1'b0, 2'd3, 0);
    step(1'b1, 2'd3, 0);
    check("midrst_led", int'(led), 7);
    run_ps(2'd3, 0);
    run_ps(2'd3, 0);
    check_period("post_rst", 0, 0, 0);

    // Randomised bursts, occasionally with reset
    for (int b = 0; b < 40; b++) begin
      logic [1:0] st;
      int         v;
      int         len;
      st  = 2'($urandom_range(0, 3));
      v   = int'($urandom_range(0, 2047));
      len = int'($urandom_range(1, 400));
      if ($urandom_range(0, 19) == 0) begin
        repeat (int'($urandom_range(1, 3))) step(1'b1, st, v);
      end
      repeat (len) step(1'b0, st, v);
    end

    step(1'b0, 2'd3, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rgb_pwm_driver
